// File: rtl/seq_alu_pkg.sv
// Shared ALUOp encodings and FSM state type for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_DIVU = 4'b0111;
  localparam logic [3:0] OP_REMU = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative shift-add multiplier / restoring divider, one step per en_i; latency WIDTH steps.
// res_o shows the value after the current step so the caller can register it on the final step.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o
);

  // hi: product accumulator / partial remainder; lo: multiplier / dividend-then-quotient.
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic             is_mul_q, res_lo_q;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    b_d     = b_q;
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    if (load_i) begin
      hi_d = '0;
      lo_d = a_i;
      b_d  = b_i;
    end else if (en_i) begin
      if (is_mul_q) begin
        if (lo_q[0]) hi_d = hi_q + b_q;
        lo_d = lo_q >> 1;
        b_d  = b_q << 1;
      end else if (!diff[WIDTH]) begin
        // A zero divisor always "fits", yielding all-ones quotient and remainder A.
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      is_mul_q <= 1'b0;
      res_lo_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      b_q  <= b_d;
      if (load_i) begin
        is_mul_q <= (op_i == OP_MUL);
        res_lo_q <= (op_i == OP_DIVU);
      end
    end
  end

  assign res_o = res_lo_q ? lo_d : hi_d;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops done 1 cycle after accept, MUL/DIVU/REMU after WIDTH+1; ready low while iterating.
// Define SEQ_ALU_MULDIV_EN to build the iterative unit; without it MUL/DIVU/REMU return 0 in one cycle.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] C
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d, single_res;
  logic [SHW-1:0]   shamt;
  logic             is_iter;

  assign shamt = B[SHW-1:0];

  always_comb begin
    single_res = '0;
    case (ALUOp)
      OP_ADD:  single_res = A + B;
      OP_SUB:  single_res = A - B;
      OP_AND:  single_res = A & B;
      OP_OR:   single_res = A | B;
      OP_SRL:  single_res = A >> shamt;
      OP_SRA:  single_res = $signed(A) >>> shamt;
      default: single_res = '0;
    endcase
  end

`ifdef SEQ_ALU_MULDIV_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             md_load, md_en;
  logic [WIDTH-1:0] md_res;

  assign is_iter = (ALUOp == OP_MUL) || (ALUOp == OP_DIVU) || (ALUOp == OP_REMU);

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (md_load),
    .en_i   (md_en),
    .op_i   (ALUOp),
    .a_i    (A),
    .b_i    (B),
    .res_o  (md_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign is_iter = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
`ifdef SEQ_ALU_MULDIV_EN
    cnt_d   = cnt_q;
    md_load = 1'b0;
    md_en   = 1'b0;
`endif
    case (state_q)
      ST_CALC: begin
`ifdef SEQ_ALU_MULDIV_EN
        md_en = 1'b1;
        cnt_d = cnt_q - CW'(1);
        // The last step's result is taken straight from the unit as the counter hits zero.
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          c_d     = md_res;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        if (start) begin
          if (is_iter) begin
            state_d = ST_CALC;
`ifdef SEQ_ALU_MULDIV_EN
            md_load = 1'b1;
            cnt_d   = CW'(WIDTH);
`endif
          end else begin
            state_d = ST_DONE;
            c_d     = single_res;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
    end
  end

  assign ready = (state_q != ST_CALC);
  assign done  = (state_q == ST_DONE);
  assign C     = c_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: driver predicts acceptance and pushes expected results, monitor checks on done.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;
`ifdef SEQ_ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0, C;
  logic [3:0]   ALUOp = '0;
  logic         ready, done;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .ALUOp(ALUOp), .ready(ready), .done(done), .C(C)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] c;
    int           due;
    logic [3:0]   op;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_until = 0;

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned      sh;
    logic [2*W-1:0]   prod;
    sh = b % W;
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SRL:  return a >> sh;
      OP_SRA:  return $signed(a) >>> sh;
      OP_MUL: begin
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return MD_EN ? prod[W-1:0] : '0;
      end
      OP_DIVU: return !MD_EN ? '0 : (b == 0) ? {W{1'b1}} : a / b;
      OP_REMU: return !MD_EN ? '0 : (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int lat(input logic [3:0] op);
    return (MD_EN && (op == OP_MUL || op == OP_DIVU || op == OP_REMU)) ? W + 1 : 1;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle, entered and left at a negedge; acceptance is predicted from the model's busy window.
  task automatic cycle_drive(input bit want, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, output bit acc);
    bit exp_rdy;
    exp_rdy = (cyc >= busy_until);
    chk("ready", W'(ready), W'(exp_rdy));
    start = want;
    ALUOp = op;
    A     = a;
    B     = b;
    acc   = want && exp_rdy;
    if (acc) begin
      sbq.push_back('{model(op, a, b), cyc + lat(op), op});
      busy_until = cyc + lat(op);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    ALUOp = 4'($urandom);
    @(negedge clk);
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) cycle_drive(1'b1, op, a, b, acc);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle_drive(1'b0, OP_ADD, '0, '0, acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_C", C, '0);
    chk("rst_ready", W'(ready), W'(1));
    chk("rst_done", W'(done), W'(0));
    sbq.delete();
    busy_until = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: C=%h with nothing outstanding (cycle %0d)", C, cyc);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("result_op%0d", e.op), C, e.c);
          chk($sformatf("latency_op%0d", e.op), W'(cyc), W'(e.due));
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].due) begin
        e = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_done: op%0d due cycle %0d, now %0d", e.op, e.due, cyc);
      end
    end
  end

  initial begin
    bit acc;
    @(negedge clk);
    do_reset();
    idle(2);

    issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    issue(OP_SRA, 32'h8000_0000, 32'h0000_0024);
    issue(OP_SRL, 32'h8000_0000, 32'h0000_0021);
    issue(OP_SUB, 32'h0, 32'h1);
    idle(1);
    issue(OP_MUL, 32'h0001_0001, 32'h0001_0001);
    for (int i = 0; i < 5; i++) cycle_drive(1'b1, OP_ADD, $urandom, $urandom, acc);
    issue(OP_DIVU, 32'd100, 32'd7);
    issue(OP_REMU, 32'd100, 32'd7);
    issue(OP_DIVU, 32'd5, 32'd0);
    issue(OP_REMU, 32'd5, 32'd0);
    issue(OP_MUL, 32'd3, 32'd4);
    issue(4'b1001, 32'd3, 32'd4);
    issue(4'b1111, $urandom, $urandom);
    idle(2);

    issue(OP_MUL, 32'd7, 32'd9);
    idle(9);
    do_reset();
    idle(40);
    issue(OP_ADD, 32'd2, 32'd3);
    idle(2);

    for (int i = 0; i < 150; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b;
      op = ($urandom % 3 == 0) ? 4'($urandom_range(6, 8)) : 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom % 4 == 0) ? W'($urandom % 40) : W'($urandom);
      if ($urandom % 10 == 0) b = '0;
      issue(op, a, b);
      idle($urandom % 3);
    end

    for (int n = 0; n < 200 && sbq.size() > 0; n++) idle(1);
    chk("drain_empty", W'(sbq.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
